// File: rtl/core_tick_sequencer_pkg.sv
// Shared types and helpers for the tick sequencer: state encoding, default
// field widths and the saturating adder used by the neuron datapath.
package core_pkg;

  localparam int unsigned DEF_NUM_NEURONS = 256;
  localparam int unsigned DEF_NUM_AXONS   = 256;
  localparam int unsigned DEF_AXON_TYPES  = 4;
  localparam int unsigned DEF_POT_W       = 9;
  localparam int unsigned DEF_NID_W       = $clog2(DEF_NUM_NEURONS);
  localparam int unsigned DEF_TYPE_W      = $clog2(DEF_AXON_TYPES);
  localparam int unsigned DEF_SUM_W       = DEF_POT_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_READ,
    S_CAPTURE,
    S_INTEGRATE,
    S_LEAK,
    S_FIRE,
    S_SPIKE,
    S_WRITE,
    S_CLEAR,
    S_ERROR
  } state_t;

  // Signed add clamped to the range of a w-bit two's complement value.
  function automatic int sat_add(int a, int b, int unsigned w);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/core_tick_sequencer_sat_accumulator.sv
// Registered signed accumulator: load a value, or add with clamping to the
// representable range of W bits.
module sat_accumulator
  import core_pkg::*;
#(
  parameter int unsigned W = DEF_POT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                add,
  input  logic signed [W-1:0] load_val,
  input  logic signed [W-1:0] add_val,
  output logic signed [W-1:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (load) acc <= load_val;
    else if (add)  acc <= W'(sat_add(int'(acc), int'(add_val), W));
  end

endmodule

// File: rtl/core_tick_sequencer.sv
// Per-tick neuron sweep: latch axon activity, integrate/leak/fire each neuron,
// emit spikes with backpressure and write potentials back. Optional watchdog
// and ERROR state are enabled by CORE_TICK_SEQ_WATCHDOG_EN.
module core_tick_sequencer
  import core_pkg::*;
#(
  parameter  int unsigned NUM_NEURONS    = DEF_NUM_NEURONS,
  parameter  int unsigned NUM_AXONS      = DEF_NUM_AXONS,
  parameter  int unsigned AXON_TYPES     = DEF_AXON_TYPES,
  parameter  int unsigned POT_W          = DEF_POT_W,
  parameter  int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned NID_W          = $clog2(NUM_NEURONS),
  localparam int unsigned TYPE_W         = $clog2(AXON_TYPES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [NUM_AXONS-1:0]         axon_activity,
  input  logic [NUM_AXONS*TYPE_W-1:0]  axon_type,
  output logic                         sched_rd_req,
  output logic                         sched_clr_req,
  output logic [NID_W-1:0]             sram_addr,
  output logic                         sram_rd_en,
  input  logic [NUM_AXONS-1:0]         sram_syn_row,
  input  logic [POT_W-1:0]             sram_potential,
  input  logic [POT_W-1:0]             sram_leak,
  input  logic [POT_W-1:0]             sram_threshold,
  input  logic [POT_W-1:0]             sram_reset_pot,
  input  logic [AXON_TYPES*POT_W-1:0]  sram_weights,
  output logic                         sram_wr_en,
  output logic [POT_W-1:0]             sram_wr_potential,
  output logic                         spike_valid,
  input  logic                         spike_ready,
  output logic [NID_W-1:0]             spike_neuron,
  output logic                         busy,
  output logic                         overrun,
  output logic                         error
);

  localparam int unsigned AX_W = $clog2(NUM_AXONS);

  state_t                    state, next;
  logic [NID_W-1:0]          neuron;
  logic [AX_W-1:0]           axon;
  logic [NUM_AXONS-1:0]      active, syn_q;
  logic signed [POT_W-1:0]   leak_q, thr_q, rpot_q, acc;
  logic signed [POT_W-1:0]   acc_load_val, acc_add_val, weight;
  logic [AXON_TYPES*POT_W-1:0] weights_q;
  logic [TYPE_W-1:0]         cur_type;
  logic                      acc_load, acc_add, fire, last_axon, last_neuron, timeout;

  assign cur_type    = axon_type[axon*TYPE_W +: TYPE_W];
  assign weight      = $signed(weights_q[cur_type*POT_W +: POT_W]);
  assign fire        = acc >= thr_q;
  assign last_axon   = axon == AX_W'(NUM_AXONS - 1);
  assign last_neuron = neuron == NID_W'(NUM_NEURONS - 1);

`ifdef CORE_TICK_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd <= '0;
    else if (state == S_IDLE)  wd <= '0;
    else if (state != S_ERROR) wd <= wd + 1'b1;
  end

  // wd counts the current busy cycle too, so TIMEOUT-1 is the last allowed one.
  assign timeout = (state != S_IDLE) && (state != S_ERROR) &&
                   (wd == WD_W'(TIMEOUT_CYCLES - 1));
  assign error   = state == S_ERROR;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      neuron    <= '0;
      axon      <= '0;
      active    <= '0;
      syn_q     <= '0;
      leak_q    <= '0;
      thr_q     <= '0;
      rpot_q    <= '0;
      weights_q <= '0;
      overrun   <= 1'b0;
    end else begin
      state   <= next;
      overrun <= tick && busy;
      case (state)
        S_LATCH: begin
          active <= axon_activity;
          neuron <= '0;
        end
        S_CAPTURE: begin
          syn_q     <= sram_syn_row;
          leak_q    <= $signed(sram_leak);
          thr_q     <= $signed(sram_threshold);
          rpot_q    <= $signed(sram_reset_pot);
          weights_q <= sram_weights;
          axon      <= '0;
        end
        S_INTEGRATE: axon   <= axon + 1'b1;
        S_WRITE:     neuron <= neuron + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next = state;
    case (state)
      S_IDLE:      if (tick) next = S_LATCH;
      S_LATCH:     next = S_READ;
      S_READ:      next = S_CAPTURE;
      S_CAPTURE:   next = S_INTEGRATE;
      S_INTEGRATE: if (last_axon) next = S_LEAK;
      S_LEAK:      next = S_FIRE;
      S_FIRE:      next = fire ? S_SPIKE : S_WRITE;
      S_SPIKE:     if (spike_ready) next = S_WRITE;
      S_WRITE:     next = last_neuron ? S_CLEAR : S_READ;
      S_CLEAR:     next = S_IDLE;
      S_ERROR:     next = S_ERROR;
      default:     next = S_IDLE;
    endcase
    if (timeout) next = S_ERROR;
  end

  always_comb begin
    sched_rd_req  = 1'b0;
    sched_clr_req = 1'b0;
    sram_rd_en    = 1'b0;
    sram_wr_en    = 1'b0;
    spike_valid   = 1'b0;
    busy          = 1'b1;
    case (state)
      S_IDLE:  busy          = 1'b0;
      S_ERROR: busy          = 1'b0;
      S_LATCH: sched_rd_req  = 1'b1;
      S_READ:  sram_rd_en    = 1'b1;
      S_SPIKE: spike_valid   = 1'b1;
      S_WRITE: sram_wr_en    = 1'b1;
      S_CLEAR: sched_clr_req = 1'b1;
      default: ;
    endcase
  end

  assign sram_addr         = neuron;
  assign spike_neuron      = neuron;
  assign sram_wr_potential = acc;

  always_comb begin
    acc_load     = 1'b0;
    acc_add      = 1'b0;
    acc_load_val = $signed(sram_potential);
    acc_add_val  = weight;
    case (state)
      S_CAPTURE:   acc_load = 1'b1;
      S_INTEGRATE: acc_add  = active[axon] & syn_q[axon];
      S_LEAK: begin
        acc_add     = 1'b1;
        acc_add_val = leak_q;
      end
      S_FIRE: begin
        acc_load     = fire;
        acc_load_val = rpot_q;
      end
      default: ;
    endcase
  end

  sat_accumulator #(.W(POT_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (acc_load),
    .add      (acc_add),
    .load_val (acc_load_val),
    .add_val  (acc_add_val),
    .acc      (acc)
  );

endmodule
